// File: rtl/subinst_arb_pkg.sv
// Shared types and constants for the round-robin sub-instance arbiter.
package subinst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int ARB_ID_W     = 4;
  localparam int N_REQ_DEF    = 10;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/subinst_rr_pick.sv
// Rotate-priority search: first set req at or above ptr, wrapping to index 0.
module subinst_rr_pick
  import subinst_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ARB_ID_W-1:0] ptr,
  output logic [N_REQ-1:0]    pick,
  output logic [ARB_ID_W-1:0] pick_id,
  output logic                found
);

  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    // Upper segment [ptr, N_REQ-1] has priority over the wrapped segment [0, ptr-1].
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        found   = 1'b1;
        pick[k] = 1'b1;
        pick_id = ARB_ID_W'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k < int'(ptr))) begin
        found   = 1'b1;
        pick[k] = 1'b1;
        pick_id = ARB_ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/subinst_arbiter.sv
// Round-robin arbiter for sub-instances with IDLE/GRANT/GAP sequencing.
// Optional hold-limit revoke is built when SUBINST_ARB_TIMEOUT_EN is defined.
// Handshake: req[i] stays high until served; the holder ends its grant by pulsing
// release_grant (sampled only in GRANT) or by dropping its req bit.
module subinst_arbiter
  import subinst_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic                release_grant,
  output logic [N_REQ-1:0]    grant,
  output logic [ARB_ID_W-1:0] grant_id,
  output logic                busy,
  output logic                timeout,
  output arb_state_t          state_dbg
);

  arb_state_t          state_q, state_d;
  logic [ARB_ID_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [ARB_ID_W-1:0] grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [N_REQ-1:0]    pick;
  logic [ARB_ID_W-1:0] pick_id;
  logic                found;
  logic                holder_req;
  logic                limit_hit;
  logic [ARB_ID_W-1:0] ptr_after;

  subinst_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .found   (found)
  );

  assign holder_req = |(req & grant_q);
  assign ptr_after  = (grant_id_q == ARB_ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef SUBINST_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
  assign limit_hit = (hold_cnt_q == HOLD_LAST);
  assign timeout   = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
`ifdef SUBINST_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          grant_d    = pick;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
`ifdef SUBINST_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        // Explicit or implicit release wins over the hold limit.
        if (release_grant || !holder_req || limit_hit) begin
          state_d    = GAP;
          ptr_d      = ptr_after;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
`ifdef SUBINST_ARB_TIMEOUT_EN
          timeout_d  = !(release_grant || !holder_req);
`endif
        end else begin
`ifdef SUBINST_ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
`ifdef SUBINST_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
`ifdef SUBINST_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_subinst_arbiter.sv
// Bench for subinst_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_subinst_arbiter;
  import subinst_arb_pkg::*;

  localparam int N  = 10;
  localparam int MH = 16;
`ifdef SUBINST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic                release_grant = 1'b0;
  logic [N-1:0]        grant;
  logic [ARB_ID_W-1:0] grant_id;
  logic                busy;
  logic                timeout;
  arb_state_t          state_dbg;

  subinst_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_grant (release_grant),
    .grant         (grant),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout       (timeout),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  // Model: who holds the grant (-1 none), whether the mandatory gap is running,
  // the fairness pointer, cycles held so far and the timeout flag.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_m(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic rl, input logic rs);
    if (!rs) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (rl || !r[m_owner]) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1'b1;
        end else if (TO_EN && m_held == MH - 1) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        m_owner = pick_m(r, m_ptr);
        m_held  = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] one;
    logic [N-1:0] exp_g;
    one   = 1;
    exp_g = (m_owner >= 0) ? (one << m_owner) : '0;
    chk("grant", 32'(grant), 32'(exp_g));
    chk("grant_id", 32'(grant_id), (m_owner >= 0) ? m_owner : 0);
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  // One clock: apply inputs, let the edge happen, update model, compare after the edge.
  task automatic step(input logic [N-1:0] r, input logic rl, input logic rs);
    req = r; release_grant = rl; rst_n = rs;
    @(posedge clk);
    model_update(r, rl, rs);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] all_ones;
    logic [N-1:0] r;
    logic         prev_busy;
    int           hold_len;
    int           pulses;
    all_ones = '1;

    // Reset state and first grant latency.
    do_reset();
    step(10'b0000000001, 1'b0, 1'b1);
    chk("first_grant", 32'(grant), 32'd1);
    step(10'b0000000001, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);

    // Full round-robin sweep with release on every grant.
    do_reset();
    prev_busy = 1'b0;
    for (int i = 0; i <= N; i++) exp_q.push_back(4'(i % N));
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step(all_ones, m_owner >= 0, 1'b1);
      if (busy && !prev_busy) chk("rr_seq", 32'(grant_id), 32'(exp_q.pop_front()));
      prev_busy = busy;
    end
    chk("rr_seq_done", 32'(exp_q.size()), 32'd0);

    // Wrap-around: serve 8 so the pointer sits at 9, then bits 2 and 9.
    do_reset();
    step(10'b01_0000_0000, 1'b0, 1'b1);
    step(10'b01_0000_0000, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    step(10'b10_0000_0100, 1'b0, 1'b1);
    chk("wrap_first", 32'(grant_id), 32'd9);
    step(10'b00_0000_0100, 1'b0, 1'b1);
    step(10'b00_0000_0100, 1'b0, 1'b1);
    step(10'b00_0000_0100, 1'b0, 1'b1);
    chk("wrap_second", 32'(grant_id), 32'd2);

    // Reset while instance 5 holds the grant; arbitration restarts from 0.
    do_reset();
    step(10'b00_0010_0000, 1'b0, 1'b1);
    step(10'b00_0010_0000, 1'b0, 1'b1);
    step(10'b00_0010_0000, 1'b0, 1'b0);
    chk("rst_mid_grant", 32'({grant, grant_id, busy, timeout}), 32'd0);
    step(10'b00_1000_1000, 1'b0, 1'b1);
    chk("restart_ptr0", 32'(grant_id), 32'd3);

`ifdef SUBINST_ARB_TIMEOUT_EN
    // Forced revoke after MAX_HOLD cycles, then the next requester.
    do_reset();
    r = 10'b00_0100_1000;
    hold_len = 0; pulses = 0;
    for (int c = 0; c < MH + 5; c++) begin
      step(r, 1'b0, 1'b1);
      if (busy && grant_id == 4'd3) hold_len++;
      if (timeout) pulses++;
    end
    chk("hold_len", 32'(hold_len), 32'(MH));
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_next", 32'(grant_id), 32'd6);

    // Release on the limit cycle wins: no timeout.
    do_reset();
    pulses = 0;
    for (int c = 0; c < MH + 4; c++) begin
      step(r, (m_owner >= 0) && (m_held == MH - 1), 1'b1);
      if (timeout) pulses++;
    end
    chk("rel_at_limit", 32'(pulses), 32'd0);
`endif

    // Random traffic: requests held until served, occasional drops, releases and resets.
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if (m_owner == b && $urandom_range(0, 5) == 0) r[b] = 1'b0;
        else if (!r[b] && $urandom_range(0, 3) == 0) r[b] = 1'b1;
      end
      step(r, $urandom_range(0, 4) == 0, $urandom_range(0, 60) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
